n64_rst_sequencer: RTL and testbench

Arbitrates and sequences the N64 console reset line between two requesters: the in-game-reset (IGR) button combo decoded from sniffed controller frames, and a soft-reset request from the NIOS CPU. It runs in the controller clock domain, downstream of the controller sniffer. It drives the open-drain `N64_nRST` enable with a fixed-length pulse, then waits for the line to be released. A hold-off window follows so that a combo still held after reset cannot retrigger.

---
 rtl/n64_rst_sequencer.sv | 151 +++++++++++++++
 tb/tb_n64_rst_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_rst_sequencer.sv
// N64 console reset sequencer: arbitrates IGR combo and CPU soft-reset requests,
// drives a fixed-length reset pulse, waits for line release, then holds off retriggers.
`ifndef IGR_RESET
`define IGR_RESET 16'h3030
`endif

module n64_rst_sequencer #(
    parameter logic [15:0]      IGR_COMBO   = `IGR_RESET,
    parameter int               HOLD_FRAMES = 8,
    parameter int               CNT_W       = 20,
    parameter logic [CNT_W-1:0] RST_LEN     = CNT_W'(20'hFFFFF),
    parameter logic [CNT_W-1:0] HOLDOFF_LEN = CNT_W'(20'hFFFFF)
) (
    input  logic        CTRL_CLK,
    input  logic        CTRL_RST,
    input  logic        igr_en_i,
    input  logic [15:0] ctrl_data_i,
    input  logic        ctrl_valid_i,
    input  logic        ctrl_lost_i,
    input  logic        cpu_rst_req_i,
    input  logic        n64_rst_sense_i,
    output logic        drv_rst_o,
    output logic        busy_o,
    output logic [1:0]  rst_src_o,
    output logic        rst_done_tgl_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_ASSERT,
        ST_WAIT_REL,
        ST_HOLDOFF
    } state_t;

    localparam logic [3:0]       HOLD_N       = 4'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0] RST_LOAD     = RST_LEN - CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = HOLDOFF_LEN - CNT_W'(1);

    state_t           state, state_n;
    logic [3:0]       frame_cnt, frame_n;
    logic [CNT_W-1:0] seq_cnt, seq_n;
    logic [1:0]       src_n;
    logic             tgl_n;
    logic             drv_n;
    logic             busy_n;
    logic             match;
    logic             igr_fire;

    always_ff @(posedge CTRL_CLK) begin
        if (CTRL_RST) begin
            state          <= ST_IDLE;
            frame_cnt      <= '0;
            seq_cnt        <= '0;
            drv_rst_o      <= 1'b0;
            busy_o         <= 1'b0;
            rst_src_o      <= 2'b00;
            rst_done_tgl_o <= 1'b0;
        end else begin
            state          <= state_n;
            frame_cnt      <= frame_n;
            seq_cnt        <= seq_n;
            drv_rst_o      <= drv_n;
            busy_o         <= busy_n;
            rst_src_o      <= src_n;
            rst_done_tgl_o <= tgl_n;
        end
    end

    always_comb begin
        state_n  = state;
        frame_n  = frame_cnt;
        seq_n    = seq_cnt;
        src_n    = rst_src_o;
        tgl_n    = rst_done_tgl_o;
        igr_fire = 1'b0;
        match    = ctrl_valid_i & igr_en_i & (ctrl_data_i == IGR_COMBO);

        case (state)
            ST_IDLE: begin
                if (match) begin
                    frame_n = 4'd1;
                    if (HOLD_N == 4'd1) begin
                        igr_fire = 1'b1;
                    end else begin
                        state_n = ST_ARM;
                    end
                end
                if (igr_fire || cpu_rst_req_i) begin
                    state_n = ST_ASSERT;
                    seq_n   = RST_LOAD;
                    src_n   = {cpu_rst_req_i, igr_fire};
                    frame_n = 4'd0;
                end
            end
            ST_ARM: begin
                if (match) begin
                    frame_n = frame_cnt + 4'd1;
                    if (frame_n == HOLD_N) begin
                        igr_fire = 1'b1;
                    end
                end else if (ctrl_valid_i || ctrl_lost_i || !igr_en_i) begin
                    state_n = ST_IDLE;
                    frame_n = 4'd0;
                end
                // A CPU request wins over any abort seen in the same cycle.
                if (igr_fire || cpu_rst_req_i) begin
                    state_n = ST_ASSERT;
                    seq_n   = RST_LOAD;
                    src_n   = {cpu_rst_req_i, igr_fire};
                    frame_n = 4'd0;
                end
            end
            ST_ASSERT: begin
                if (seq_cnt == '0) begin
                    state_n = ST_WAIT_REL;
                    seq_n   = '1;
                end else begin
                    seq_n = seq_cnt - CNT_W'(1);
                end
            end
            ST_WAIT_REL: begin
                // Timeout exit covers an external device holding the line low.
                if (n64_rst_sense_i || seq_cnt == '0) begin
                    state_n = ST_HOLDOFF;
                    seq_n   = HOLDOFF_LOAD;
                    tgl_n   = ~rst_done_tgl_o;
                end else begin
                    seq_n = seq_cnt - CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (seq_cnt == '0) begin
                    state_n = ST_IDLE;
                    frame_n = 4'd0;
                end else begin
                    seq_n = seq_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                frame_n = 4'd0;
            end
        endcase

        drv_n  = (state_n == ST_ASSERT);
        busy_n = (state_n == ST_ASSERT) || (state_n == ST_WAIT_REL) ||
                 (state_n == ST_HOLDOFF);
    end

endmodule

// File: tb/tb_n64_rst_sequencer.sv
// Directed bench for n64_rst_sequencer: IGR fire, ARM aborts, collision,
// stuck line timeout, mid-pulse reset and held-combo hold-off.
`timescale 1ns/1ps

module tb_n64_rst_sequencer;

    localparam logic [15:0] COMBO = 16'h3030;
    localparam int          CW    = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        igr_en = 1'b0;
    logic [15:0] ctrl_data = 16'h0000;
    logic        ctrl_valid = 1'b0;
    logic        ctrl_lost = 1'b0;
    logic        cpu_req = 1'b0;
    logic        sense = 1'b1;
    logic        drv_rst;
    logic        busy;
    logic [1:0]  rst_src;
    logic        tgl;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int toggles = 0;
    logic drv_prev = 1'b0;
    logic tgl_prev = 1'bx;

    n64_rst_sequencer #(
        .IGR_COMBO   (COMBO),
        .HOLD_FRAMES (3),
        .CNT_W       (CW),
        .RST_LEN     (CW'(16)),
        .HOLDOFF_LEN (CW'(8))
    ) dut (
        .CTRL_CLK        (clk),
        .CTRL_RST        (rst),
        .igr_en_i        (igr_en),
        .ctrl_data_i     (ctrl_data),
        .ctrl_valid_i    (ctrl_valid),
        .ctrl_lost_i     (ctrl_lost),
        .cpu_rst_req_i   (cpu_req),
        .n64_rst_sense_i (sense),
        .drv_rst_o       (drv_rst),
        .busy_o          (busy),
        .rst_src_o       (rst_src),
        .rst_done_tgl_o  (tgl)
    );

    always #5 clk = ~clk;

    // Count rising edges of the reset drive and every toggle of the done flag.
    always @(negedge clk) begin
        if (drv_rst === 1'b1 && drv_prev !== 1'b1) pulses++;
        drv_prev = drv_rst;
        if (!$isunknown(tgl) && tgl !== tgl_prev) begin
            if (!$isunknown(tgl_prev)) toggles++;
            tgl_prev = tgl;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] d);
        ctrl_data  = d;
        ctrl_valid = 1'b1;
        tick();
        ctrl_valid = 1'b0;
        ctrl_data  = 16'h0000;
    endtask

    task automatic count_drv(output int hi);
        hi = 0;
        while (drv_rst === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
    endtask

    task automatic count_busy(output int b);
        b = 0;
        while (busy === 1'b1 && b < 200) begin
            b++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (drv_rst !== 1'b0) begin errors++; $display("FAIL reset_drv: got %b want 0", drv_rst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rst_src !== 2'b00) begin errors++; $display("FAIL reset_src: got %b want 00", rst_src); end
        checks++; if (tgl !== 1'b0) begin errors++; $display("FAIL reset_tgl: got %b want 0", tgl); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_igr_fire();
        int hi, b;
        logic t0;
        igr_en = 1'b1;
        sense  = 1'b1;
        send_frame(COMBO);
        repeat (99) tick();
        send_frame(COMBO);
        repeat (99) tick();
        checks++; if (drv_rst !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fire_early: drv %b busy %b want 0 0", drv_rst, busy); end
        t0 = tgl;
        send_frame(COMBO);
        checks++; if (drv_rst !== 1'b1) begin errors++; $display("FAIL fire_drv_rise: got %b want 1", drv_rst); end
        checks++; if (rst_src !== 2'b01) begin errors++; $display("FAIL fire_src: got %b want 01", rst_src); end
        count_drv(hi);
        checks++; if (hi != 16) begin errors++; $display("FAIL fire_pulse_len: got %0d want 16", hi); end
        checks++; if (busy !== 1'b1 || tgl !== t0) begin errors++; $display("FAIL fire_wait_rel: busy %b tgl %b want 1 %b", busy, tgl, t0); end
        tick();
        checks++; if (tgl !== ~t0) begin errors++; $display("FAIL fire_tgl: got %b want %b", tgl, ~t0); end
        count_busy(b);
        checks++; if (b != 8) begin errors++; $display("FAIL fire_holdoff_len: got %0d want 8", b); end
    endtask

    task automatic test_arm_abort();
        int p0;
        // Variant 0: bad frame, 1: controller lost, 2: IGR disabled mid-ARM.
        for (int v = 0; v < 3; v++) begin
            p0 = pulses;
            igr_en = 1'b1;
            send_frame(COMBO); repeat (3) tick();
            send_frame(COMBO); repeat (3) tick();
            if (v == 0) begin
                send_frame(16'h0000);
            end else if (v == 1) begin
                ctrl_lost = 1'b1; tick(); ctrl_lost = 1'b0;
            end else begin
                igr_en = 1'b0; tick(); igr_en = 1'b1;
            end
            repeat (3) tick();
            send_frame(COMBO); repeat (3) tick();
            send_frame(COMBO); repeat (3) tick();
            send_frame(16'h0000);
            repeat (30) tick();
            checks++; if (pulses != p0 || busy !== 1'b0) begin errors++; $display("FAIL arm_abort_%0d: pulses %0d busy %b want %0d 0", v, pulses, busy, p0); end
        end
    endtask

    task automatic test_collision();
        int hi, b, p0, t0;
        p0 = pulses;
        t0 = toggles;
        igr_en = 1'b1;
        send_frame(COMBO); repeat (3) tick();
        send_frame(COMBO); repeat (3) tick();
        cpu_req = 1'b1;
        send_frame(COMBO);
        cpu_req = 1'b0;
        checks++; if (drv_rst !== 1'b1 || rst_src !== 2'b11) begin errors++; $display("FAIL collision_src: drv %b src %b want 1 11", drv_rst, rst_src); end
        hi = 0;
        while (drv_rst === 1'b1 && hi < 100) begin
            hi++;
            cpu_req = (hi == 4);
            tick();
        end
        cpu_req = 1'b0;
        checks++; if (hi != 16) begin errors++; $display("FAIL collision_len: got %0d want 16", hi); end
        count_busy(b);
        repeat (30) tick();
        checks++; if (pulses != p0 + 1) begin errors++; $display("FAIL collision_pulses: got %0d want %0d", pulses - p0, 1); end
        checks++; if (toggles != t0 + 1) begin errors++; $display("FAIL collision_toggles: got %0d want %0d", toggles - t0, 1); end
    endtask

    task automatic test_stuck_line();
        int hi, w, b, t0;
        logic tg;
        t0 = toggles;
        sense = 1'b0;
        cpu_req = 1'b1; tick(); cpu_req = 1'b0;
        checks++; if (rst_src !== 2'b10) begin errors++; $display("FAIL stuck_src: got %b want 10", rst_src); end
        count_drv(hi);
        checks++; if (hi != 16) begin errors++; $display("FAIL stuck_pulse_len: got %0d want 16", hi); end
        tg = tgl;
        w = 0;
        while (busy === 1'b1 && tgl === tg && w < 10000) begin
            w++;
            tick();
        end
        checks++; if (w != (1 << CW)) begin errors++; $display("FAIL stuck_timeout: got %0d want %0d", w, 1 << CW); end
        count_busy(b);
        checks++; if (b != 8) begin errors++; $display("FAIL stuck_holdoff_len: got %0d want 8", b); end
        checks++; if (toggles != t0 + 1) begin errors++; $display("FAIL stuck_toggles: got %0d want 1", toggles - t0); end
        sense = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_pulse();
        int hi, b;
        cpu_req = 1'b1; tick(); cpu_req = 1'b0;
        repeat (4) tick();
        checks++; if (drv_rst !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b want 1", drv_rst); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (drv_rst !== 1'b0 || busy !== 1'b0 || rst_src !== 2'b00 || tgl !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: drv %b busy %b src %b tgl %b want 0 0 00 0", drv_rst, busy, rst_src, tgl);
        end
        repeat (3) tick();
        cpu_req = 1'b1; tick(); cpu_req = 1'b0;
        checks++; if (rst_src !== 2'b10) begin errors++; $display("FAIL midrst_src: got %b want 10", rst_src); end
        count_drv(hi);
        checks++; if (hi != 16) begin errors++; $display("FAIL midrst_pulse_len: got %0d want 16", hi); end
        count_busy(b);
        repeat (3) tick();
    endtask

    task automatic test_held_combo();
        int n, p0, b;
        p0 = pulses;
        igr_en = 1'b1;
        sense  = 1'b1;
        send_frame(COMBO); tick();
        send_frame(COMBO); tick();
        send_frame(COMBO);
        checks++; if (drv_rst !== 1'b1) begin errors++; $display("FAIL held_first: got %b want 1", drv_rst); end
        n = 0;
        ctrl_data = COMBO;
        while (busy === 1'b1 && n < 200) begin
            ctrl_valid = n[0];
            n++;
            tick();
        end
        ctrl_valid = 1'b0;
        checks++; if (busy !== 1'b0 || pulses != p0 + 1) begin errors++; $display("FAIL held_release: busy %b pulses %0d want 0 1", busy, pulses - p0); end
        send_frame(COMBO);
        checks++; if (drv_rst !== 1'b0) begin errors++; $display("FAIL held_fresh1: got %b want 0", drv_rst); end
        tick();
        send_frame(COMBO);
        checks++; if (drv_rst !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL held_fresh2: drv %b busy %b want 0 0", drv_rst, busy); end
        tick();
        send_frame(COMBO);
        checks++; if (drv_rst !== 1'b1 || rst_src !== 2'b01) begin errors++; $display("FAIL held_fresh3: drv %b src %b want 1 01", drv_rst, rst_src); end
        count_busy(b);
        checks++; if (pulses != p0 + 2) begin errors++; $display("FAIL held_pulses: got %0d want 2", pulses - p0); end
    endtask

    initial begin
        test_reset();
        test_igr_fire();
        test_arm_abort();
        test_collision();
        test_stuck_line();
        test_reset_mid_pulse();
        test_held_combo();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
